instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage that feeds the 4-state CPU control FSM.
- Owns the program counter and the instruction register.
- Issues requests to instruction memory over a req/valid handshake with variable latency, and splits the fetched word into opcode and operand for control and datapath.
- Applies the control FSM's pc_en / pc_load / jmp / halt strobes to the PC.

Parameters:
- ADDR_W, 5, PC and instruction-memory address width.
- DATA_W, 8, instruction word width; opcode = ir[DATA_W-1 -: 3], operand = ir[ADDR_W-1:0].
- TIMEOUT, 16, maximum WAIT cycles without imem_valid before abort; legal range 2..255.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- fetch_start  input  1  fetch request; driven by the control FSM's memIns_en.
- pc_en  input  1  increment PC.
- pc_load  input  1  non-sequential PC update.
- jmp  input  1  qualifies pc_load: 1 = jump to operand, 0 = skip.
- halt  input  1  freeze PC and block new fetches.
- imem_req  output  1  memory request, held high until imem_valid or timeout.
- imem_addr  output  ADDR_W  request address.
- imem_rdata  input  DATA_W  instruction word.
- imem_valid  input  1  imem_rdata is valid this cycle.
- opcode  output  3  ir opcode field.
- operand  output  ADDR_W  ir operand field.
- ir_valid  output  1  ir holds a completed fetch.
- fetch_busy  output  1  high while in WAIT.
- fetch_err  output  1  sticky timeout flag.
- pc  output  ADDR_W  current PC.

Behaviour:
- Reset values (async, rst high): pc=0, ir=0 (so opcode=0, operand=0), ir_valid=0, imem_req=0, imem_addr=0, fetch_busy=0, fetch_err=0, state=IDLE, timeout counter=0.
- Reset mid-fetch: imem_req drops immediately. A later imem_valid in IDLE is ignored.
- State IDLE:
  - imem_req=0.
  - If fetch_start=1 and halt=0 at a clock edge: imem_addr<=pc, ir_valid<=0, counter<=0, next state WAIT.
  - If fetch_start=1 and halt=1: the request is ignored.
  - imem_valid is ignored in IDLE.
- State WAIT:
  - imem_req=1 and fetch_busy=1 (both decoded from state). imem_addr is held stable.
  - fetch_start is ignored.
  - On imem_valid=1: ir<=imem_rdata, ir_valid<=1, next state IDLE.
  - Otherwise counter increments.
  - If counter==TIMEOUT-1 and imem_valid=0: fetch_err<=1, ir_valid<=0, ir unchanged, next state IDLE.
  - imem_valid on the timeout cycle wins; no error is flagged.
- Latency: fetch_start sampled at edge E0 → imem_req high from E0. imem_valid sampled at edge Ek → opcode/operand/ir_valid updated after Ek. Minimum is 1 cycle from request to IR update.
- PC update, evaluated every edge, priority order:
  - halt=1: pc holds.
  - pc_load=1 and jmp=1: pc<=operand (the current ir operand).
  - pc_load=1 and jmp=0: pc<=pc+1 (skip).
  - pc_en=1: pc<=pc+1.
  - otherwise: hold.
  - pc_load together with pc_en gives a single update per the priority above, never a double increment.
- Wrap: pc+1 is modulo 2^ADDR_W (31→0 with the default width).
- PC updates during WAIT are legal and do not affect imem_addr of the in-flight request.
- halt during WAIT: the in-flight fetch completes normally. Only new fetches are blocked.
- fetch_err clears only on rst.
- opcode and operand are combinational slices of ir.

Test Plan:
- Reset, then fetch_start for 1 cycle with memory returning 8'hA3 at 3-cycle latency:
  - imem_addr=0 and imem_req high for 3 cycles.
  - opcode=5, operand=3, ir_valid=1 after the third edge.
- ir operand=5, pc=2, then pc_load=1, jmp=1 → pc=5. Then pc_load=1, jmp=0, pc_en=1 in the same cycle → pc=6 (not 7).
- pc=31, pc_en pulse → pc=0; next fetch issues imem_addr=0.
- halt=1 with fetch_start=1 in IDLE → no imem_req, pc frozen. Assert halt mid-WAIT, return valid=8'h00 → ir loads 0 and ir_valid=1.
- TIMEOUT=16, memory never responds:
  - imem_req high exactly 16 cycles, then fetch_err=1 and state IDLE.
  - A late imem_valid is ignored; fetch_err stays 1 until rst.
- Assert rst during WAIT → imem_req=0 immediately. A valid pulse after rst release leaves ir=0 and ir_valid=0.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit and instruction memory.
//   imem_req   : request, held high while a fetch is outstanding
//   imem_addr  : request address, stable for the whole request
//   imem_rdata : returned instruction word
//   imem_valid : imem_rdata is valid this cycle
// master = fetch unit, slave = instruction memory.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage for the 4-state CPU control FSM. Owns the program counter and
// the instruction register, fetches words over a req/valid handshake with
// variable latency and a bounded wait, and applies the control strobes to PC.
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   fetch_start  : start a fetch (control FSM memIns_en)
//   pc_en        : increment PC
//   pc_load      : non-sequential PC update, qualified by jmp
//   jmp          : with pc_load, 1 = jump to operand, 0 = skip one word
//   halt         : freeze PC and block new fetches
//   imem         : instruction memory bus (master side)
//   opcode       : ir[DATA_W-1 -: 3]
//   operand      : ir[ADDR_W-1:0]
//   ir_valid     : ir holds a completed fetch
//   fetch_busy   : a fetch is outstanding
//   fetch_err    : sticky timeout flag, cleared only by rst
//   pc           : current program counter
module instr_fetch_unit #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_start,
  input  logic                       pc_en,
  input  logic                       pc_load,
  input  logic                       jmp,
  input  logic                       halt,
  instr_fetch_unit_if.master         imem,
  output logic [2:0]                 opcode,
  output logic [ADDR_W-1:0]          operand,
  output logic                       ir_valid,
  output logic                       fetch_busy,
  output logic                       fetch_err,
  output logic [ADDR_W-1:0]          pc
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);
  localparam logic [7:0]        CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      addr_q     <= '0;
      err_q      <= 1'b0;
      pc_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      pc_q       <= pc_d;
    end
  end

  // Fetch FSM. The counter holds the number of WAIT cycles already spent
  // without a response; imem_valid on the last allowed cycle still wins.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    addr_d     = addr_q;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (fetch_start && !halt) begin
          addr_d     = pc_q;
          ir_valid_d = 1'b0;
          cnt_d      = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_valid) begin
          ir_d       = imem.imem_rdata;
          ir_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d      = 1'b1;
          ir_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // PC update: one update per edge, highest-priority strobe wins, so
  // pc_load together with pc_en never double-increments.
  always_comb begin
    pc_d = pc_q;
    if (halt) begin
      pc_d = pc_q;
    end else if (pc_load && jmp) begin
      pc_d = ir_q[ADDR_W-1:0];
    end else if (pc_load || pc_en) begin
      pc_d = pc_q + PC_ONE;
    end
  end

  // Request and busy decode from state so an async reset drops them at once.
  assign imem.imem_req  = (state_q == S_WAIT);
  assign imem.imem_addr = addr_q;
  assign fetch_busy     = (state_q == S_WAIT);
  assign opcode         = ir_q[DATA_W-1 -: 3];
  assign operand        = ir_q[ADDR_W-1:0];
  assign ir_valid       = ir_valid_q;
  assign fetch_err      = err_q;
  assign pc             = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fetch_start = 1'b0, pc_en = 1'b0, pc_load = 1'b0, jmp = 1'b0, halt = 1'b0;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              ir_valid, fetch_busy, fetch_err;
  logic [ADDR_W-1:0] pc;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) imem_if ();

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_start (fetch_start),
    .pc_en       (pc_en),
    .pc_load     (pc_load),
    .jmp         (jmp),
    .halt        (halt),
    .imem        (imem_if.master),
    .opcode      (opcode),
    .operand     (operand),
    .ir_valid    (ir_valid),
    .fetch_busy  (fetch_busy),
    .fetch_err   (fetch_err),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a fetch is either outstanding or not; an outstanding
  // fetch gives up once it has waited TIMEOUT cycles without a response.
  int              m_pc;
  int              m_ir;
  bit              m_irv;
  bit              m_err;
  bit              m_busy;
  int              m_addr;
  int              m_waited;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_irv = 0; m_err = 0; m_busy = 0; m_addr = 0; m_waited = 0;
  endtask

  task automatic model_edge();
    int opnd;
    opnd = m_ir % (1 << ADDR_W);
    if (!m_busy) begin
      if (fetch_start && !halt) begin
        m_busy = 1; m_addr = m_pc; m_irv = 0; m_waited = 0;
      end
    end else begin
      if (imem_if.imem_valid) begin
        m_ir = int'(imem_if.imem_rdata); m_irv = 1; m_busy = 0;
      end else begin
        m_waited++;
        if (m_waited == TIMEOUT) begin
          m_err = 1; m_irv = 0; m_busy = 0;
        end
      end
    end
    if (halt) ;
    else if (pc_load && jmp) m_pc = opnd;
    else if (pc_load || pc_en) m_pc = (m_pc + 1) % (1 << ADDR_W);
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".pc"},       32'(pc),                32'(m_pc));
    check_eq({tag, ".opcode"},   32'(opcode),            32'((m_ir >> (DATA_W - 3)) & 7));
    check_eq({tag, ".operand"},  32'(operand),           32'(m_ir % (1 << ADDR_W)));
    check_eq({tag, ".ir_valid"}, 32'(ir_valid),          32'(m_irv));
    check_eq({tag, ".req"},      32'(imem_if.imem_req),  32'(m_busy));
    check_eq({tag, ".busy"},     32'(fetch_busy),        32'(m_busy));
    check_eq({tag, ".addr"},     32'(imem_if.imem_addr), 32'(m_addr));
    check_eq({tag, ".err"},      32'(fetch_err),         32'(m_err));
  endtask

  task automatic clear_inputs();
    fetch_start = 0; pc_en = 0; pc_load = 0; jmp = 0; halt = 0;
    imem_if.imem_valid = 0; imem_if.imem_rdata = '0;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    check_eq("rst.req_drop", 32'(imem_if.imem_req), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    compare_all("rst");
  endtask

  task automatic fetch_word(input logic [7:0] w, input string tag);
    clear_inputs();
    fetch_start = 1;
    step({tag, ".start"});
    clear_inputs();
    imem_if.imem_valid = 1; imem_if.imem_rdata = w;
    step({tag, ".resp"});
    clear_inputs();
  endtask

  initial begin
    int n;
    model_reset();
    clear_inputs();
    @(posedge clk); #1;
    do_reset();

    // First fetch, 3-cycle latency, word A3.
    fetch_start = 1;
    step("f1.e0");
    check_eq("f1.addr0", 32'(imem_if.imem_addr), 32'd0);
    clear_inputs();
    step("f1.e1");
    step("f1.e2");
    check_eq("f1.req_e2", 32'(imem_if.imem_req), 32'd1);
    imem_if.imem_valid = 1; imem_if.imem_rdata = 8'hA3;
    step("f1.e3");
    clear_inputs();
    check_eq("f1.opcode", 32'(opcode), 32'd5);
    check_eq("f1.operand", 32'(operand), 32'd3);
    check_eq("f1.ir_valid", 32'(ir_valid), 32'd1);
    check_eq("f1.req_off", 32'(imem_if.imem_req), 32'd0);

    // Jump and skip priority.
    fetch_word(8'h05, "f2");
    pc_en = 1; step("inc1"); step("inc2"); clear_inputs();
    check_eq("pc_is_2", 32'(pc), 32'd2);
    pc_load = 1; jmp = 1; step("jump"); clear_inputs();
    check_eq("jump_pc", 32'(pc), 32'd5);
    pc_load = 1; jmp = 0; pc_en = 1; step("skip"); clear_inputs();
    check_eq("skip_pc", 32'(pc), 32'd6);

    // Wrap 31 -> 0, then fetch from 0.
    fetch_word(8'h1F, "f3");
    pc_load = 1; jmp = 1; step("j31"); clear_inputs();
    check_eq("pc_31", 32'(pc), 32'd31);
    pc_en = 1; step("wrap"); clear_inputs();
    check_eq("pc_wrap", 32'(pc), 32'd0);
    fetch_start = 1; step("f4.start"); clear_inputs();
    check_eq("f4.addr", 32'(imem_if.imem_addr), 32'd0);
    imem_if.imem_valid = 1; imem_if.imem_rdata = 8'h3C; step("f4.resp"); clear_inputs();

    // Halt blocks new fetch and freezes PC; halt mid-WAIT lets the fetch finish.
    pc_en = 1; step("pre_halt"); clear_inputs();
    halt = 1; fetch_start = 1; pc_en = 1; step("halt_idle"); clear_inputs();
    check_eq("halt.no_req", 32'(imem_if.imem_req), 32'd0);
    check_eq("halt.pc", 32'(pc), 32'd1);
    fetch_start = 1; step("f5.start"); clear_inputs();
    halt = 1; step("f5.halt_wait");
    imem_if.imem_valid = 1; imem_if.imem_rdata = 8'h00; step("f5.resp"); clear_inputs();
    check_eq("f5.ir_zero", 32'({opcode, operand}), 32'd0);
    check_eq("f5.ir_valid", 32'(ir_valid), 32'd1);

    // Timeout: no response ever.
    fetch_start = 1; step("to.start"); clear_inputs();
    n = 0;
    for (int i = 0; i < 40 && imem_if.imem_req; i++) begin
      n++;
      step("to.wait");
    end
    check_eq("to.req_cycles", 32'(n), 32'(TIMEOUT));
    check_eq("to.err", 32'(fetch_err), 32'd1);
    check_eq("to.idle", 32'(fetch_busy), 32'd0);
    imem_if.imem_valid = 1; imem_if.imem_rdata = 8'hFF; step("to.late"); clear_inputs();
    check_eq("to.late_irv", 32'(ir_valid), 32'd0);
    fetch_word(8'h42, "f6");
    check_eq("to.sticky", 32'(fetch_err), 32'd1);

    // Reset during WAIT, then a stray valid.
    fetch_start = 1; step("rw.start"); clear_inputs();
    step("rw.wait");
    do_reset();
    imem_if.imem_valid = 1; imem_if.imem_rdata = 8'hFF; step("rw.stray"); clear_inputs();
    check_eq("rw.ir", 32'({opcode, operand}), 32'd0);
    check_eq("rw.irv", 32'(ir_valid), 32'd0);
    check_eq("rw.err_clr", 32'(fetch_err), 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        fetch_start = ($urandom_range(0, 2) == 0);
        halt        = ($urandom_range(0, 7) == 0);
        pc_en       = $urandom_range(0, 1) != 0;
        pc_load     = ($urandom_range(0, 4) == 0);
        jmp         = $urandom_range(0, 1) != 0;
        imem_if.imem_valid = m_busy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 5) == 0);
        imem_if.imem_rdata = DATA_W'($urandom);
        step("rnd");
      end
    end
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
